// File: rtl/shot_turn_ctrl.sv
// shot_turn_ctrl: billiards shot sequencer (aim, release, roll, settle, turn scoring).
// Optional macro SHOT_TIMEOUT_EN adds a no-motion timeout in WAIT_MOVE.
`default_nettype none

module shot_turn_ctrl #(
  parameter int NUM_BALLS     = 4,
  parameter int SETTLE_FRAMES = 8,
  parameter int MOVE_TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 keyUp,
  input  logic                 keyDown,
  input  logic                 keyLeft,
  input  logic                 keyRight,
  input  logic                 keyEnter,
  input  logic [NUM_BALLS-1:0] ballMoving,
  input  logic [NUM_BALLS-1:0] ballPotted,
  output logic                 chargeUp,
  output logic                 chargeDown,
  output logic                 chargeLeft,
  output logic                 chargeRight,
  output logic                 releaseBall,
  output logic                 currentPlayer,
  output logic                 foul,
  output logic [7:0]           shotCount,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_AIM       = 3'd0,
    S_RELEASE   = 3'd1,
    S_WAIT_MOVE = 3'd2,
    S_ROLLING   = 3'd3,
    S_TURN_END  = 3'd4
  } state_e;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE_FRAMES);

  generate
    if (NUM_BALLS < 2) begin : g_bad_num_balls
      $error("shot_turn_ctrl: NUM_BALLS must be at least 2");
    end
    if (SETTLE_FRAMES < 1 || SETTLE_FRAMES > 255) begin : g_bad_settle
      $error("shot_turn_ctrl: SETTLE_FRAMES out of range 1..255");
    end
    if (MOVE_TIMEOUT < 1 || MOVE_TIMEOUT > 255) begin : g_bad_timeout
      $error("shot_turn_ctrl: MOVE_TIMEOUT out of range 1..255");
    end
  endgenerate

  state_e               state_q;
  logic [4:0]           key_q;
  logic [3:0]           charge_q;
  logic [3:0]           charge_d;
  logic                 release_q;
  logic                 player_q;
  logic                 foul_q;
  logic [7:0]           shot_cnt_q;
  logic [7:0]           settle_cnt_q;
  logic [NUM_BALLS-1:0] potted_q;

  logic [4:0]           key_raw;
  logic [4:0]           key_edge;
  logic [NUM_BALLS-1:0] potted_eval;
  logic                 any_moving;
  logic                 enter_ok;
  logic                 keep_player;

`ifdef SHOT_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(MOVE_TIMEOUT);
  logic [7:0]           timeout_cnt_q;
`endif

  // Key bit order: {enter, right, left, down, up}.
  assign key_raw     = {keyEnter, keyRight, keyLeft, keyDown, keyUp};
  assign key_edge    = key_raw & ~key_q;
  assign any_moving  = |ballMoving;
  // Pots arriving in the evaluation cycle itself still count for the turn.
  assign potted_eval = potted_q | ballPotted;
  assign keep_player = ~potted_eval[0] & (|potted_eval[NUM_BALLS-1:1]);

  always_comb begin
    enter_ok = (state_q == S_AIM) && key_edge[4] && !any_moving;
    charge_d = '0;
    if ((state_q == S_AIM) && !enter_ok) begin
      charge_d[0] = key_edge[0] & ~key_edge[1];
      charge_d[1] = key_edge[1] & ~key_edge[0];
      charge_d[2] = key_edge[2] & ~key_edge[3];
      charge_d[3] = key_edge[3] & ~key_edge[2];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_AIM;
      key_q        <= '0;
      charge_q     <= '0;
      release_q    <= 1'b0;
      player_q     <= 1'b0;
      foul_q       <= 1'b0;
      shot_cnt_q   <= '0;
      settle_cnt_q <= '0;
      potted_q     <= '0;
`ifdef SHOT_TIMEOUT_EN
      timeout_cnt_q <= '0;
`endif
    end else begin
      key_q     <= key_raw;
      charge_q  <= charge_d;
      release_q <= 1'b0;
      if (state_q != S_AIM) begin
        potted_q <= potted_eval;
      end

      case (state_q)
        S_AIM: begin
          if (enter_ok) begin
            state_q   <= S_RELEASE;
            release_q <= 1'b1;
          end
        end

        S_RELEASE: begin
          potted_q     <= '0;
          foul_q       <= 1'b0;
          settle_cnt_q <= '0;
`ifdef SHOT_TIMEOUT_EN
          timeout_cnt_q <= '0;
`endif
          state_q      <= S_WAIT_MOVE;
        end

        S_WAIT_MOVE: begin
          if (any_moving) begin
            settle_cnt_q <= '0;
            state_q      <= S_ROLLING;
          end
`ifdef SHOT_TIMEOUT_EN
          else if (timeout_cnt_q == TIMEOUT_C) begin
            state_q <= S_TURN_END;
          end else if (startOfFrame) begin
            timeout_cnt_q <= timeout_cnt_q + 8'd1;
          end
`endif
        end

        S_ROLLING: begin
          if (settle_cnt_q == SETTLE_C) begin
            state_q <= S_TURN_END;
          end else if (any_moving) begin
            settle_cnt_q <= '0;
          end else if (startOfFrame) begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end

        S_TURN_END: begin
          shot_cnt_q <= shot_cnt_q + 8'd1;
          foul_q     <= potted_eval[0];
          if (!keep_player) begin
            player_q <= ~player_q;
          end
          state_q <= S_AIM;
        end

        default: state_q <= S_AIM;
      endcase
    end
  end

  assign chargeUp      = charge_q[0];
  assign chargeDown    = charge_q[1];
  assign chargeLeft    = charge_q[2];
  assign chargeRight   = charge_q[3];
  assign releaseBall   = release_q;
  assign currentPlayer = player_q;
  assign foul          = foul_q;
  assign shotCount     = shot_cnt_q;
  assign state         = state_q;

endmodule

`default_nettype wire

// File: doc/shot_turn_ctrl.md
SHOT_TURN_CTRL -- requirements
Module: shot_turn_ctrl

Interface
REQ-001 SHALL have parameter NUM_BALLS, default 4, number of balls on the table; bit 0 is the white ball.
REQ-002 SHALL have parameter SETTLE_FRAMES, default 8, consecutive all-stopped frames needed to end a shot (range 1..255).
REQ-003 SHALL have parameter MOVE_TIMEOUT, default 16, frames allowed for motion to start after release (range 1..255).
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port resetN, input, 1, reset; one clock, reset is asynchronous and active-low.
REQ-006 SHALL have port startOfFrame, input, 1, one-cycle pulse at each frame start.
REQ-007 SHALL have ports keyUp, keyDown, keyLeft, keyRight, keyEnter, input, 1 each, raw key levels.
REQ-008 SHALL have port ballMoving, input, NUM_BALLS, bit i high while ball i has nonzero X or Y speed.
REQ-009 SHALL have port ballPotted, input, NUM_BALLS, one-cycle pulse when ball i enters a hole.
REQ-010 SHALL have ports chargeUp, chargeDown, chargeLeft, chargeRight, output, 1 each, one-cycle charge pulses to the white-ball motion block.
REQ-011 SHALL have port releaseBall, output, 1, one-cycle shot release pulse.
REQ-012 SHALL have port currentPlayer, output, 1, player whose turn it is (0 or 1).
REQ-013 SHALL have port foul, output, 1, high from TURN_END until the next release when the last shot potted the white ball.
REQ-014 SHALL have port shotCount, output, 8, number of completed shots, wraps 255->0.
REQ-015 SHALL have port state, output, 3, encoding AIM=0, RELEASE=1, WAIT_MOVE=2, ROLLING=3, TURN_END=4.

Function
REQ-016 SHALL register each key level and derive a rising-edge pulse (current high, previous low).
REQ-017 In AIM only, a key rising edge SHALL produce exactly one charge pulse in the cycle after the edge; outside AIM charge outputs SHALL be 0.
REQ-018 Simultaneous up and down edges SHALL produce neither chargeUp nor chargeDown; likewise left and right.
REQ-019 AIM SHALL go to RELEASE on keyEnter rising edge only when ballMoving == 0; otherwise the edge is ignored.
REQ-020 RELEASE SHALL assert releaseBall for exactly one cycle, clear the potted register and foul, then go to WAIT_MOVE.
REQ-021 WAIT_MOVE SHALL go to ROLLING in the cycle after any ballMoving bit is high.
REQ-022 ROLLING SHALL count startOfFrame pulses with ballMoving == 0 and reset the count to 0 whenever any bit is high; at count == SETTLE_FRAMES go to TURN_END.
REQ-023 In all states other than AIM, ballPotted pulses SHALL be ORed into a sticky NUM_BALLS-bit potted register.
REQ-024 TURN_END, lasting one cycle, SHALL: increment shotCount; set foul = potted[0]; toggle currentPlayer if potted[0] is set or no other bit is set; otherwise keep currentPlayer; then go to AIM.
REQ-025 A ballPotted pulse in the same cycle as the TURN_END evaluation SHALL be included in that evaluation.

Reset
REQ-026 On resetN low, SHALL immediately enter AIM and clear all outputs, key history, counters and the potted register, including mid-shot.
REQ-027 Key edge history SHALL be held at 0 during reset, so a key held through reset SHALL produce an edge on the first cycle after reset.

Configuration
REQ-028 With macro SHOT_TIMEOUT_EN defined, WAIT_MOVE SHALL count startOfFrame pulses and, at MOVE_TIMEOUT with no motion, go to TURN_END.
REQ-029 Without SHOT_TIMEOUT_EN, WAIT_MOVE SHALL wait indefinitely for motion, and no timeout counter SHALL exist.

Verification
REQ-030 Reset, then pulse keyUp 3 times in AIM -> 3 single-cycle chargeUp pulses, state=0.
REQ-031 keyUp and keyDown rise together -> no chargeUp or chargeDown pulse.
REQ-032 keyEnter edge while ballMoving=4'b0010 -> no release, state stays 0.
REQ-033 Full shot: Enter, ballMoving=1 for 5 frames, then 0 for 8 frames, ballPotted[2] pulsed -> one releaseBall pulse, shotCount=1, currentPlayer unchanged, foul=0.
REQ-034 Shot with ballPotted[0] pulsed -> foul=1, currentPlayer toggled.
REQ-035 With SHOT_TIMEOUT_EN defined, release with no motion for 16 frames -> TURN_END, player toggled; resetN pulsed during ROLLING -> state=0, shotCount=0.
